// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and default widths for period_timer
package timer_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
    localparam int NUM_BITS_DEF = 4;
    localparam int TICK_CNT_W_DEF = 8;
endpackage

// File: rtl/flex_counter.sv
// flex_counter: up-counter from 0 that reloads 1 after reaching the rollover value
module flex_counter
    import timer_pkg::*;
#(
    parameter int NUM_BITS = NUM_BITS_DEF
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                clear,
    input  logic                count_enable,
    input  logic [NUM_BITS-1:0] rollover_val,
    output logic [NUM_BITS-1:0] count_out,
    output logic                rollover_flag
);
    assign rollover_flag = count_out == rollover_val;
    // count while enabled; clear wins over enable
    always_ff @(posedge clk or negedge nrst)
        if (!nrst)
            count_out <= '0;
        else if (clear)
            count_out <= '0;
        else if (count_enable)
            count_out <= rollover_flag ? NUM_BITS'(1) : count_out + 1'b1;
endmodule

// File: rtl/period_timer.sv
// period_timer: one-shot or periodic tick generator with saturating tick count
module period_timer
    import timer_pkg::*;
#(
    parameter int NUM_BITS   = NUM_BITS_DEF,
    parameter int TICK_CNT_W = TICK_CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  periodic,
    input  logic [NUM_BITS-1:0]   period,
    output logic                  busy,
    output logic                  tick,
    output logic                  done,
    output logic                  err,
    output logic [TICK_CNT_W-1:0] tick_cnt
);
    state_t              state;
    logic [NUM_BITS-1:0] per_q;
    logic [NUM_BITS-1:0] unused_count;
    logic                periodic_q;
    logic                roll;
    logic                accept;
    assign busy   = state == RUN;
    assign tick   = busy & roll & ~stop;
    assign done   = tick & ~periodic_q;
    assign accept = ~busy & start & |period;
    flex_counter #(.NUM_BITS(NUM_BITS)) u_cnt (
        .clk          (clk),
        .nrst         (nrst),
        .clear        (~busy),
        .count_enable (busy),
        .rollover_val (per_q),
        .count_out    (unused_count),
        .rollover_flag(roll)
    );
    // state machine and configuration captured at an accepted start
    always_ff @(posedge clk or negedge nrst)
        if (!nrst) begin
            state      <= IDLE;
            per_q      <= '0;
            periodic_q <= 1'b0;
        end else if (accept) begin
            state      <= RUN;
            per_q      <= period;
            periodic_q <= periodic;
        end else if (busy & (stop | done))
            state <= IDLE;
    // flag a start rejected for a zero period
    always_ff @(posedge clk or negedge nrst)
        if (!nrst)
            err <= 1'b0;
        else
            err <= ~busy & start & ~|period;
    // saturating count of ticks since the last accepted start
    always_ff @(posedge clk or negedge nrst)
        if (!nrst)
            tick_cnt <= '0;
        else if (accept)
            tick_cnt <= '0;
        else if (tick & ~&tick_cnt)
            tick_cnt <= tick_cnt + 1'b1;
endmodule

// File: tb/tb_period_timer.sv
// tb_period_timer: model-checked directed bench for period_timer
module tb_period_timer;
    logic       tb_clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       periodic = 1'b0;
    logic [3:0] period = 4'd0;
    logic       busy, tick, done, err;
    logic [7:0] tick_cnt;
    int checks = 0;
    int errors = 0;
    bit m_run, m_per, m_err;
    int m_k, m_p, m_cnt;
    bit m_tick, m_done;
    int nt, nd;

    period_timer dut (
        .clk     (tb_clk),
        .nrst    (nrst),
        .start   (start),
        .stop    (stop),
        .periodic(periodic),
        .period  (period),
        .busy    (busy),
        .tick    (tick),
        .done    (done),
        .err     (err),
        .tick_cnt(tick_cnt)
    );

    always #5 tb_clk = ~tb_clk;

    // the k-th edge after an accepted start ticks when k is a multiple of the period
    assign m_tick = m_run && m_k > 0 && (m_k % m_p) == 0 && !stop;
    assign m_done = m_tick && !m_per;

    always @(posedge tb_clk or negedge nrst) begin
        if (!nrst) begin
            m_run = 0; m_per = 0; m_err = 0; m_k = 0; m_p = 1; m_cnt = 0;
        end else if (!m_run) begin
            m_err = start && period == 0;
            if (start && period != 0) begin
                m_run = 1; m_k = 0; m_p = int'(period); m_per = periodic; m_cnt = 0;
            end
        end else begin
            m_err = 0;
            if (m_tick && m_cnt < 255) m_cnt++;
            if (stop || m_done) m_run = 0;
            else m_k++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge tb_clk) begin
        chk("model_busy", 32'(busy), 32'(m_run));
        chk("model_tick", 32'(tick), 32'(m_tick));
        chk("model_done", 32'(done), 32'(m_done));
        chk("model_err", 32'(err), 32'(m_err));
        chk("model_tick_cnt", 32'(tick_cnt), 32'(m_cnt));
    end

    task automatic cyc();
        @(posedge tb_clk);
        #1;
    endtask

    task automatic one_shot5();
        start = 1; periodic = 0; period = 4'd5;
        cyc();
        start = 0;
        chk("os5_busy_e0", 32'(busy), 1);
        chk("os5_cnt_e0", 32'(tick_cnt), 0);
        nt = 0; nd = 0;
        for (int j = 1; j <= 5; j++) begin
            cyc();
            if (tick) nt++;
            if (done) nd++;
            if (j == 5) begin
                chk("os5_tick_e5", 32'(tick), 1);
                chk("os5_done_e5", 32'(done), 1);
            end
        end
        chk("os5_ticks", 32'(nt), 1);
        chk("os5_dones", 32'(nd), 1);
        cyc();
        chk("os5_busy_end", 32'(busy), 0);
        chk("os5_cnt_end", 32'(tick_cnt), 1);
    endtask

    initial begin
        repeat (2) @(posedge tb_clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(tick_cnt), 0);
        nrst = 1;
        cyc();
        one_shot5();
        // periodic, period 3, with an ignored start mid-run
        start = 1; periodic = 1; period = 4'd3;
        cyc();
        start = 0;
        nt = 0; nd = 0;
        for (int j = 1; j <= 10; j++) begin
            cyc();
            if (tick) nt++;
            if (done) nd++;
            start = (j == 5); period = (j == 5) ? 4'd0 : 4'd3;
            if (j == 6) chk("run_start_no_err", 32'(err), 0);
        end
        start = 0;
        chk("p3_ticks", 32'(nt), 3);
        chk("p3_dones", 32'(nd), 0);
        chk("p3_cnt", 32'(tick_cnt), 3);
        cyc();
        cyc();
        chk("p3_tick_e12", 32'(tick), 1);
        stop = 1;
        #1;
        chk("stop_masks_tick", 32'(tick), 0);
        chk("stop_busy", 32'(busy), 1);
        cyc();
        stop = 0;
        chk("stop_idle", 32'(busy), 0);
        chk("stop_cnt_hold", 32'(tick_cnt), 3);
        // zero period rejected
        start = 1; period = 4'd0; periodic = 0;
        cyc();
        start = 0;
        chk("err_high", 32'(err), 1);
        chk("err_busy", 32'(busy), 0);
        chk("err_cnt_kept", 32'(tick_cnt), 3);
        cyc();
        chk("err_low", 32'(err), 0);
        // period 15 one-shot, started together with stop in IDLE
        start = 1; stop = 1; period = 4'd15;
        cyc();
        start = 0; stop = 0;
        chk("p15_busy", 32'(busy), 1);
        nt = 0;
        for (int j = 1; j <= 15; j++) begin
            cyc();
            if (tick) nt++;
            if (j == 14) chk("p15_no_tick_e14", 32'(tick), 0);
            if (j == 15) chk("p15_tick_e15", 32'(tick), 1);
        end
        chk("p15_ticks", 32'(nt), 1);
        cyc();
        chk("p15_idle", 32'(busy), 0);
        // period 1, long run to saturation
        start = 1; periodic = 1; period = 4'd1;
        cyc();
        start = 0;
        chk("p1_no_tick_e0", 32'(tick), 0);
        nt = 0;
        repeat (300) begin
            cyc();
            if (tick) nt++;
        end
        chk("p1_ticks", 32'(nt), 300);
        chk("p1_sat", 32'(tick_cnt), 255);
        // asynchronous reset between edges while running
        @(posedge tb_clk);
        #2 nrst = 0;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_tick", 32'(tick), 0);
        chk("arst_done", 32'(done), 0);
        chk("arst_err", 32'(err), 0);
        chk("arst_cnt", 32'(tick_cnt), 0);
        #1 nrst = 1;
        repeat (3) cyc();
        chk("arst_wait_idle", 32'(busy), 0);
        one_shot5();
        repeat (2) cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
